draw_ball: RTL and testbench
============================

# draw_ball

Ball stage of the Pong video pipeline, placed directly downstream of `draw_rect`. It moves a square ball once per frame and bounces it off the top wall, the bottom wall and both paddles, using the paddle `y_position` values. It raises a one-cycle score pulse when the ball leaves the court, then re-serves from the centre. It overlays the ball on the incoming pixel stream and forwards all VGA timing with one cycle of latency.

## Interface
Parameters:
- `BALL_SIZE`, 12: ball side in pixels (square).
- `SPEED_X`, 4: horizontal step per frame, in pixels.
- `SPEED_Y`, 3: vertical step per frame, in pixels.
- `SERVE_DELAY`, 60: number of frames the ball rests at centre before moving.
- `BALL_COLOR`, 12'hf_f_0: ball RGB.
- `PADDLE_H`, 100; `PADDLE_W`, 15; `LEFT_X`, 30; `RIGHT_X`, 979: paddle geometry. Paddle spans x∈[X, X+PADDLE_W] and y∈[y, y+PADDLE_H], both inclusive.
- Court size is 1024×768, taken from `HOR_PIXELS` / `VER_PIXELS` in `vga_pkg`.

Ports:
- `clk` in 1: pixel clock. The block has one clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `paddle_left_y` in 11: top row of the left paddle (from `draw_rect`).
- `paddle_right_y` in 11: top row of the right paddle.
- `vga` in `vga_if.in`: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb.
- `vga_out` out `vga_if.out`: the same fields, registered.
- `ball_x` out 11: ball left column.
- `ball_y` out 11: ball top row.
- `score_left` out 1: one-cycle pulse when the ball exits on the right (left player scores).
- `score_right` out 1: one-cycle pulse when the ball exits on the left (right player scores).

## Operation
- **Frame tick:** one-cycle pulse on the rising edge of `vga.vblnk`, detected with a registered copy of `vblnk`. All motion and state updates happen only on the tick cycle.
- **Position arithmetic:** ball position is held in 12-bit signed registers. Velocity `dx`/`dy` is held as sign bits, with magnitudes `SPEED_X`/`SPEED_Y`. Candidate position is nx = x ± SPEED_X, ny = y ± SPEED_Y.
- **States:**
  - SERVE: ball held at centre (506, 378). A frame counter increments on each tick. When the counter equals `SERVE_DELAY-1`, the counter clears and the state moves to PLAY on that tick.
  - PLAY: on each tick, rules are evaluated in the order listed below; the first match wins.
  - SCORED: lasts exactly one cycle. The matching score pulse is high during it. The ball is recentred and the state moves to SERVE.
- **PLAY rules, in priority order:**
  1. **Left exit:** dx<0 and nx<0 → `score_right`, set dx=+, go to SCORED.
  2. **Right exit:** dx>0 and nx+BALL_SIZE>1024 → `score_left`, set dx=−, go to SCORED.
  3. **Left paddle hit:** dx<0, nx≤LEFT_X+PADDLE_W, x>LEFT_X+PADDLE_W, and vertical overlap → x=LEFT_X+PADDLE_W+1, dx=+.
     - Vertical overlap means y+BALL_SIZE−1 ≥ paddle_y and y ≤ paddle_y+PADDLE_H.
  4. **Right paddle hit:** dx>0, nx+BALL_SIZE−1≥RIGHT_X, x+BALL_SIZE−1<RIGHT_X, and vertical overlap → x=RIGHT_X−BALL_SIZE, dx=−.
  5. Otherwise x=nx.
  - **Vertical, evaluated independently in the same tick:**
    - ny≤0 → y=0, dy=+.
    - ny+BALL_SIZE≥768 → y=768−BALL_SIZE, dy=−.
    - Otherwise y=ny.
  - A paddle hit and a wall bounce in the same tick both apply.
- **Serve direction:** after a point, the ball travels toward the player who conceded. dy keeps its sign across the point.
- **Paddle sampling:** paddle inputs are sampled only on the tick. Values between ticks are ignored.
- **Overlay:** `rgb_nxt` = `BALL_COLOR` when `vga.hcount`∈[x, x+BALL_SIZE−1] and `vga.vcount`∈[y, y+BALL_SIZE−1]. Otherwise `rgb_nxt` = `vga.rgb`. The ball is drawn in every state.

## Timing
- **Pipeline latency:** every `vga_out` field equals the corresponding `vga` field (or `rgb_nxt`) one cycle after it appears on the input.
- **Reset values:**
  - All `vga_out` fields 0.
  - ball_x=506, ball_y=378.
  - dx=+, dy=+.
  - State SERVE, frame counter 0.
  - Both score outputs 0, and the vblnk history register 0.
- **Reset mid-operation:** reset takes effect in the cycle it is asserted, from any state. A pending score pulse is dropped.
- **Position update timing:** `ball_x`/`ball_y` update in the cycle after the tick, so they are stable throughout the next visible frame.
- **Score pulse timing:** the score pulse is asserted one cycle after the tick that detected the exit.
- **Rule-3/4 boundary:** with the tie-breaks defined in rules 3–4, the ball can never tunnel through a paddle at SPEED_X < PADDLE_W.

## Test plan
- **Reset / serve hold:** apply reset, then 59 ticks → ball stays at (506,378) and `vga_out.rgb`=0 throughout. On the 60th tick the state enters PLAY; after the next tick, ball_x=510 and ball_y=381.
- **Overlay latency:** input hcount=506, vcount=378, rgb=12'h00f → the next cycle gives `vga_out.rgb`=12'hff0 and `vga_out.hcount`=506. Input hcount=518 → `vga_out.rgb`=12'h00f.
- **Top bounce:** force y=2, dy=− in PLAY, then one tick → y=0 and dy=+. The following tick gives y=3.
- **Left paddle hit:** x=48, dx=−, y=300, paddle_left_y=250, then one tick → x=46 and dx=+. Repeating with paddle_left_y=400 (no overlap) gives x=44 with no bounce.
- **Miss / score:** x=2, dx=−, no paddle overlap, then one tick → `score_right` high for exactly 1 cycle. The ball then recentres with dx=+, and 60 ticks of SERVE follow before it moves.
- **Right exit:** x=1010, dx=+, paddle_right_y=0, y=700, then one tick → `score_left` pulses once and dx becomes −.

Source files
------------

// File: rtl/draw_ball_if.sv
// VGA timing/pixel bundle shared by the Pong drawing stages, plus the court geometry package.
package vga_pkg;
    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;
endpackage

interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_ball.sv
// Pong ball stage: per-frame ball motion with wall/paddle bounces and scoring,
// plus a one-cycle overlay of the ball on the incoming VGA stream.
module draw_ball import vga_pkg::*; #(
    parameter int          BALL_SIZE   = 12,
    parameter int          SPEED_X     = 4,
    parameter int          SPEED_Y     = 3,
    parameter int          SERVE_DELAY = 60,
    parameter logic [11:0] BALL_COLOR  = 12'hf_f_0,
    parameter int          PADDLE_H    = 100,
    parameter int          PADDLE_W    = 15,
    parameter int          LEFT_X      = 30,
    parameter int          RIGHT_X     = 979
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] paddle_left_y,
    input  logic [10:0] paddle_right_y,
    vga_if.in           vga,
    vga_if.out          vga_out,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        score_left,
    output logic        score_right
);

    typedef logic signed [12:0] coord_t;
    typedef enum logic [1:0] {SERVE, PLAY, SCORED} state_t;

    localparam int     CNT_W      = $clog2(SERVE_DELAY + 1);
    localparam coord_t BS         = coord_t'(BALL_SIZE);
    localparam coord_t SX         = coord_t'(SPEED_X);
    localparam coord_t SY         = coord_t'(SPEED_Y);
    localparam coord_t PH         = coord_t'(PADDLE_H);
    localparam coord_t LEFT_EDGE  = coord_t'(LEFT_X + PADDLE_W);
    localparam coord_t RIGHT_FACE = coord_t'(RIGHT_X);
    localparam coord_t COURT_W    = coord_t'(HOR_PIXELS);
    localparam coord_t COURT_H    = coord_t'(VER_PIXELS);
    localparam coord_t CX         = coord_t'((HOR_PIXELS - BALL_SIZE) / 2);
    localparam coord_t CY         = coord_t'((VER_PIXELS - BALL_SIZE) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

    state_t             state, state_nxt;
    logic signed [11:0] x_p0, y_p0, x_nxt, y_nxt;
    logic               dx_neg, dy_neg, dx_nxt, dy_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               score_left_nxt, score_right_nxt;
    logic               vblnk_d, tick;
    coord_t             x_c, y_c, nx, ny, hc, vc, pl, pr;
    logic               ovl_left, ovl_right, in_ball;
    logic [11:0]        rgb_nxt;

    assign tick = vga.vblnk & ~vblnk_d;
    assign x_c  = coord_t'(x_p0);
    assign y_c  = coord_t'(y_p0);
    assign nx   = dx_neg ? x_c - SX : x_c + SX;
    assign ny   = dy_neg ? y_c - SY : y_c + SY;
    assign pl   = coord_t'({2'b00, paddle_left_y});
    assign pr   = coord_t'({2'b00, paddle_right_y});
    assign hc   = coord_t'({2'b00, vga.hcount});
    assign vc   = coord_t'({2'b00, vga.vcount});

    // Overlap uses the pre-move row, matching the paddle positions sampled on this tick.
    assign ovl_left  = (y_c + BS - 13'sd1 >= pl) && (y_c <= pl + PH);
    assign ovl_right = (y_c + BS - 13'sd1 >= pr) && (y_c <= pr + PH);

    assign in_ball = (hc >= x_c) && (hc <= x_c + BS - 13'sd1) &&
                     (vc >= y_c) && (vc <= y_c + BS - 13'sd1);
    assign rgb_nxt = in_ball ? BALL_COLOR : vga.rgb;

    always_comb begin
        state_nxt       = state;
        x_nxt           = x_p0;
        y_nxt           = y_p0;
        dx_nxt          = dx_neg;
        dy_nxt          = dy_neg;
        cnt_nxt         = cnt;
        score_left_nxt  = 1'b0;
        score_right_nxt = 1'b0;
        case (state)
            SERVE: begin
                x_nxt = CX[11:0];
                y_nxt = CY[11:0];
                if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = PLAY;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    // Horizontal rules are prioritised; the vertical wall check runs alongside.
                    if (dx_neg && (nx < 13'sd0)) begin
                        score_right_nxt = 1'b1;
                        dx_nxt          = 1'b0;
                        state_nxt       = SCORED;
                    end else if (!dx_neg && (nx + BS > COURT_W)) begin
                        score_left_nxt = 1'b1;
                        dx_nxt         = 1'b1;
                        state_nxt      = SCORED;
                    end else if (dx_neg && (nx <= LEFT_EDGE) && (x_c > LEFT_EDGE) && ovl_left) begin
                        x_nxt  = 12'(LEFT_EDGE + 13'sd1);
                        dx_nxt = 1'b0;
                    end else if (!dx_neg && (nx + BS - 13'sd1 >= RIGHT_FACE) &&
                                 (x_c + BS - 13'sd1 < RIGHT_FACE) && ovl_right) begin
                        x_nxt  = 12'(RIGHT_FACE - BS);
                        dx_nxt = 1'b1;
                    end else begin
                        x_nxt = nx[11:0];
                    end

                    if (ny <= 13'sd0) begin
                        y_nxt  = '0;
                        dy_nxt = 1'b0;
                    end else if (ny + BS >= COURT_H) begin
                        y_nxt  = 12'(COURT_H - BS);
                        dy_nxt = 1'b1;
                    end else begin
                        y_nxt = ny[11:0];
                    end
                end
            end
            SCORED: begin
                x_nxt     = CX[11:0];
                y_nxt     = CY[11:0];
                cnt_nxt   = '0;
                state_nxt = SERVE;
            end
            default: state_nxt = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SERVE;
            x_p0           <= CX[11:0];
            y_p0           <= CY[11:0];
            dx_neg         <= 1'b0;
            dy_neg         <= 1'b0;
            cnt            <= '0;
            score_left     <= 1'b0;
            score_right    <= 1'b0;
            vblnk_d        <= 1'b0;
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            state          <= state_nxt;
            x_p0           <= x_nxt;
            y_p0           <= y_nxt;
            dx_neg         <= dx_nxt;
            dy_neg         <= dy_nxt;
            cnt            <= cnt_nxt;
            score_left     <= score_left_nxt;
            score_right    <= score_right_nxt;
            vblnk_d        <= vga.vblnk;
            vga_out.hcount <= vga.hcount;
            vga_out.vcount <= vga.vcount;
            vga_out.hsync  <= vga.hsync;
            vga_out.vsync  <= vga.vsync;
            vga_out.hblnk  <= vga.hblnk;
            vga_out.vblnk  <= vga.vblnk;
            vga_out.rgb    <= rgb_nxt;
        end
    end

    assign ball_x = x_p0[10:0];
    assign ball_y = y_p0[10:0];

endmodule

// File: tb/tb_draw_ball.sv
// Directed bench for draw_ball: serve hold, overlay latency, wall/paddle bounces, scoring and reset.
module tb_draw_ball;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] paddle_left_y;
    logic [10:0] paddle_right_y;
    logic [10:0] ball_x, ball_y;
    logic        score_left, score_right;
    int          checks   = 0;
    int          failures = 0;

    vga_if vga_in ();
    vga_if vga_o ();

    draw_ball dut (
        .clk            (clk),
        .rst            (rst),
        .paddle_left_y  (paddle_left_y),
        .paddle_right_y (paddle_right_y),
        .vga            (vga_in),
        .vga_out        (vga_o),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .score_left     (score_left),
        .score_right    (score_right)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic check_ball(input string tag, input int ex, input int ey);
        check({tag, ".x"}, 32'(ball_x), 32'(ex));
        check({tag, ".y"}, 32'(ball_y), 32'(ey));
    endtask

    // Returns just after the clock edge on which the frame tick was sampled.
    task automatic tick();
        @(posedge clk); #1;
        vga_in.vblnk = 1'b1;
        @(posedge clk); #1;
        vga_in.vblnk = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_score(input string tag, input bit left_scores);
        check({tag, ".pulse_l"}, 32'(score_left),  32'(left_scores));
        check({tag, ".pulse_r"}, 32'(score_right), 32'(!left_scores));
        @(posedge clk); #1;
        check({tag, ".after_l"}, 32'(score_left),  32'd0);
        check({tag, ".after_r"}, 32'(score_right), 32'd0);
        check_ball({tag, ".centre"}, 506, 378);
    endtask

    task automatic serve_hold(input string tag);
        for (int i = 1; i <= 59; i++) begin
            tick();
            check_ball(tag, 506, 378);
        end
        tick();
        check_ball({tag, ".t60"}, 506, 378);
    endtask

    initial begin
        rst            = 1'b1;
        paddle_left_y  = 11'd2047;
        paddle_right_y = 11'd0;
        vga_in.hcount  = 11'd5;
        vga_in.vcount  = 11'd7;
        vga_in.hsync   = 1'b1;
        vga_in.vsync   = 1'b1;
        vga_in.hblnk   = 1'b1;
        vga_in.vblnk   = 1'b0;
        vga_in.rgb     = 12'habc;
        repeat (3) @(posedge clk);
        #1;
        check("rst.rgb",    32'(vga_o.rgb),    32'd0);
        check("rst.hcount", 32'(vga_o.hcount), 32'd0);
        check("rst.vcount", 32'(vga_o.vcount), 32'd0);
        check("rst.hsync",  32'(vga_o.hsync),  32'd0);
        check("rst.hblnk",  32'(vga_o.hblnk),  32'd0);
        check_ball("rst", 506, 378);
        check("rst.score_l", 32'(score_left),  32'd0);
        check("rst.score_r", 32'(score_right), 32'd0);

        rst          = 1'b0;
        vga_in.hsync = 1'b0;
        vga_in.vsync = 1'b0;
        vga_in.hblnk = 1'b0;

        // Overlay: ball occupies columns 506..517, rows 378..389.
        vga_in.hcount = 11'd506; vga_in.vcount = 11'd378; vga_in.rgb = 12'h00f; vga_in.hsync = 1'b1;
        @(posedge clk); #1;
        check("ovl.in.rgb",    32'(vga_o.rgb),    32'hff0);
        check("ovl.in.hcount", 32'(vga_o.hcount), 32'd506);
        check("ovl.in.vcount", 32'(vga_o.vcount), 32'd378);
        check("ovl.in.hsync",  32'(vga_o.hsync),  32'd1);
        vga_in.hcount = 11'd518; vga_in.hsync = 1'b0; vga_in.vsync = 1'b1;
        @(posedge clk); #1;
        check("ovl.right_out.rgb", 32'(vga_o.rgb),   32'h00f);
        check("ovl.right_out.vsync", 32'(vga_o.vsync), 32'd1);
        vga_in.hcount = 11'd517; vga_in.vcount = 11'd389; vga_in.vsync = 1'b0;
        @(posedge clk); #1;
        check("ovl.corner.rgb", 32'(vga_o.rgb), 32'hff0);
        vga_in.vcount = 11'd390;
        @(posedge clk); #1;
        check("ovl.below.rgb", 32'(vga_o.rgb), 32'h00f);
        vga_in.hcount = 11'd0; vga_in.vcount = 11'd0; vga_in.rgb = 12'h000;
        @(posedge clk); #1;

        // Serve hold, then first move down-right.
        for (int i = 1; i <= 59; i++) begin
            tick();
            check_ball("serve0", 506, 378);
            check("serve0.rgb", 32'(vga_o.rgb), 32'd0);
        end
        tick();
        check_ball("serve0.t60", 506, 378);
        tick();
        check_ball("play0.k1", 510, 381);

        // Bottom wall at k=126, right exit (paddle far above) at k=127.
        ticks(125);
        check_ball("bottom.k126", 1010, 756);
        tick();
        check_score("exit_right", 1'b1);

        // Serve leftwards/upwards; left paddle overlaps at k=116.
        serve_hold("serve1");
        tick();
        check_ball("play1.k1", 502, 375);
        paddle_left_y = 11'd0;
        ticks(115);
        check_ball("lhit.k116", 46, 30);
        ticks(10);
        check_ball("top.k126", 86, 0);
        tick();
        check_ball("top.k127", 90, 3);
        paddle_left_y = 11'd2047;
        ticks(230);
        check_ball("cross.k357", 1010, 693);
        tick();
        check_score("exit_right2", 1'b1);

        // Leftwards with paddle out of reach: pass the paddle, bounce off bottom, exit left.
        paddle_left_y = 11'd400;
        serve_hold("serve2");
        tick();
        check_ball("play2.k1", 502, 381);
        ticks(115);
        check_ball("lmiss.k116", 42, 726);
        ticks(10);
        check_ball("lmiss.k126", 2, 756);
        tick();
        check_score("exit_left", 1'b0);

        // After a left exit the serve heads right; dy stays upward.
        serve_hold("serve3");
        tick();
        check_ball("play3.k1", 510, 375);

        // Reset mid-play recentres and returns to a held serve.
        ticks(2);
        check_ball("play3.k3", 518, 369);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_ball("midrst", 506, 378);
        check("midrst.score_l", 32'(score_left),  32'd0);
        check("midrst.score_r", 32'(score_right), 32'd0);
        tick();
        check_ball("midrst.held", 506, 378);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
